// File: rtl/ahb_interconnect_nslv_pkg.sv
// ahb_interconnect_nslv_pkg
//   Shared definitions for the single-master AHB interconnect.
//   - HTRANS / HRESP encodings
//   - default-slave state enum
//   - slot_base(): start address of slave slot idx, computed in 64 bits so
//     that the slot window compare never wraps at the top of the address space
package ahb_interconnect_nslv_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } dflt_state_e;

    // First byte address of slot idx; wide enough that base + N slots cannot overflow.
    function automatic logic [63:0] slot_base(input logic [63:0] base, input int idx, input int shift);
        return base + (64'(idx) << shift);
    endfunction

endpackage

// File: rtl/ahb_interconnect_nslv_if.sv
// ahb_interconnect_nslv_if
//   Bus bundle for the interconnect: the master-side AHB signals (M_*) and the
//   fanned-out slave-side signals (S_*), slave responses packed per slave.
//   Modports:
//     slave  - the interconnect's view (it is the slave of the CPU master and
//              drives the S_* fan-out)
//     master - the environment's view (CPU master plus the peripheral slaves)
interface ahb_interconnect_nslv_if #(
    parameter int SLAVE_NUM  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]           M_HADDR;
    logic [1:0]                      M_HTRANS;
    logic                            M_HWRITE;
    logic [2:0]                      M_HSIZE;
    logic [2:0]                      M_HBURST;
    logic [3:0]                      M_HPORT;
    logic [DATA_WIDTH-1:0]           M_HWDATA;
    logic [DATA_WIDTH-1:0]           M_HRDATA;
    logic [1:0]                      M_HRESP;
    logic                            M_HREADY;

    logic [ADDR_WIDTH-1:0]           S_HADDR;
    logic [1:0]                      S_HTRANS;
    logic                            S_HWRITE;
    logic [2:0]                      S_HSIZE;
    logic [2:0]                      S_HBURST;
    logic [3:0]                      S_HPORT;
    logic [DATA_WIDTH-1:0]           S_HWDATA;
    logic [SLAVE_NUM-1:0]            S_HSEL;
    logic [SLAVE_NUM*DATA_WIDTH-1:0] S_HRDATA;
    logic [SLAVE_NUM*2-1:0]          S_HRESP;
    logic [SLAVE_NUM-1:0]            S_HREADYOUT;

    modport slave (
        input  M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HBURST, M_HPORT, M_HWDATA,
        output M_HRDATA, M_HRESP, M_HREADY,
        output S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HBURST, S_HPORT, S_HWDATA, S_HSEL,
        input  S_HRDATA, S_HRESP, S_HREADYOUT
    );

    modport master (
        output M_HADDR, M_HTRANS, M_HWRITE, M_HSIZE, M_HBURST, M_HPORT, M_HWDATA,
        input  M_HRDATA, M_HRESP, M_HREADY,
        input  S_HADDR, S_HTRANS, S_HWRITE, S_HSIZE, S_HBURST, S_HPORT, S_HWDATA, S_HSEL,
        output S_HRDATA, S_HRESP, S_HREADYOUT
    );

endinterface

// File: rtl/ahb_interconnect_nslv_default_slave.sv
// ahb_interconnect_nslv_default_slave
//   Answers accepted NONSEQ/SEQ transfers that hit no slave with the two-cycle
//   AHB ERROR response, and logs faults for debug.
//   Ports:
//     HCLK, H_nREST  clock, async active-low reset
//     accept         an unmapped NONSEQ/SEQ address phase is accepted this cycle
//     fault_addr     address of that address phase
//     flt_clr        synchronous clear of the fault log
//     hready, hresp  registered data-phase response for the default slave
//     flt_addr       address of the first fault since reset/clear
//     flt_cnt        saturating fault count
module ahb_interconnect_nslv_default_slave
    import ahb_interconnect_nslv_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_W      = 16
) (
    input  logic                  HCLK,
    input  logic                  H_nREST,
    input  logic                  accept,
    input  logic [ADDR_WIDTH-1:0] fault_addr,
    input  logic                  flt_clr,
    output logic                  hready,
    output logic [1:0]            hresp,
    output logic [ADDR_WIDTH-1:0] flt_addr,
    output logic [CNT_W-1:0]      flt_cnt
);

    dflt_state_e           state_r;
    logic                  hready_r;
    logic [1:0]            hresp_r;
    logic [ADDR_WIDTH-1:0] flt_addr_r;
    logic [CNT_W-1:0]      flt_cnt_r;
    logic                  flt_first_r;
    logic                  enter_err1_s;

    // A new error sequence starts whenever a fault is accepted outside ERR1
    // (ERR1 holds HREADY low, so no address phase can complete there).
    assign enter_err1_s = accept & (state_r != DS_ERR1);

    // Error-response FSM with registered HREADY/HRESP.
    always_ff @(posedge HCLK or negedge H_nREST) begin
        if (!H_nREST) begin
            state_r  <= DS_IDLE;
            hready_r <= 1'b1;
            hresp_r  <= HRESP_OKAY;
        end else begin
            case (state_r)
                DS_IDLE, DS_ERR2: begin
                    if (accept) begin
                        state_r  <= DS_ERR1;
                        hready_r <= 1'b0;
                        hresp_r  <= HRESP_ERROR;
                    end else begin
                        state_r  <= DS_IDLE;
                        hready_r <= 1'b1;
                        hresp_r  <= HRESP_OKAY;
                    end
                end
                DS_ERR1: begin
                    state_r  <= DS_ERR2;
                    hready_r <= 1'b1;
                    hresp_r  <= HRESP_ERROR;
                end
                default: begin
                    state_r  <= DS_IDLE;
                    hready_r <= 1'b1;
                    hresp_r  <= HRESP_OKAY;
                end
            endcase
        end
    end

    // Fault log: clear has priority, a fault in the same cycle is then counted
    // as the first fault after the clear.
    always_ff @(posedge HCLK or negedge H_nREST) begin
        if (!H_nREST) begin
            flt_addr_r  <= '0;
            flt_cnt_r   <= '0;
            flt_first_r <= 1'b0;
        end else if (flt_clr) begin
            if (enter_err1_s) begin
                flt_addr_r  <= fault_addr;
                flt_cnt_r   <= CNT_W'(1);
                flt_first_r <= 1'b1;
            end else begin
                flt_addr_r  <= '0;
                flt_cnt_r   <= '0;
                flt_first_r <= 1'b0;
            end
        end else if (enter_err1_s) begin
            if (flt_cnt_r != {CNT_W{1'b1}}) begin
                flt_cnt_r <= flt_cnt_r + CNT_W'(1);
            end else begin
                flt_cnt_r <= flt_cnt_r;
            end
            if (!flt_first_r) begin
                flt_addr_r  <= fault_addr;
                flt_first_r <= 1'b1;
            end else begin
                flt_addr_r  <= flt_addr_r;
                flt_first_r <= flt_first_r;
            end
        end else begin
            flt_addr_r  <= flt_addr_r;
            flt_cnt_r   <= flt_cnt_r;
            flt_first_r <= flt_first_r;
        end
    end

    assign hready   = hready_r;
    assign hresp    = hresp_r;
    assign flt_addr = flt_addr_r;
    assign flt_cnt  = flt_cnt_r;

endmodule

// File: rtl/ahb_interconnect_nslv.sv
// ahb_interconnect_nslv
//   Single-master AHB interconnect for SLAVE_NUM memory-mapped slaves.
//   Address phase: slot decode drives S_HSEL; S_HADDR carries the slot offset,
//   the other control/data signals pass straight through.
//   Data phase: a registered select (one-hot slave or built-in default slave)
//   steers HRDATA/HRESP/HREADY back to the master with no added latency.
//   Ports:
//     HCLK, H_nREST          clock, async active-low reset
//     bus (slave modport)    master-side and slave-side AHB signals
//     FLT_ADDR, FLT_CNT      first unmapped-fault address, saturating count
//     FLT_CLR                synchronous clear of the fault log
module ahb_interconnect_nslv
    import ahb_interconnect_nslv_pkg::*;
#(
    parameter int                    SLAVE_NUM  = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h43C0_0000,
    parameter int                    SLOT_SHIFT = 16
) (
    input  logic                  HCLK,
    input  logic                  H_nREST,
    ahb_interconnect_nslv_if.slave bus,
    output logic [ADDR_WIDTH-1:0] FLT_ADDR,
    output logic [15:0]           FLT_CNT,
    input  logic                  FLT_CLR
);

    localparam logic [63:0]           SLOT_SIZE = 64'd1 << SLOT_SHIFT;
    localparam logic [ADDR_WIDTH-1:0] SLOT_MASK = ADDR_WIDTH'(SLOT_SIZE - 64'd1);

    logic [SLAVE_NUM-1:0]  hit_s;
    logic                  unmapped_s;
    logic [63:0]           addr_ext_s;
    logic [SLAVE_NUM-1:0]  dsel_r;
    logic                  dsel_dflt_r;
    logic [DATA_WIDTH-1:0] sel_rdata_s;
    logic [1:0]            sel_resp_s;
    logic                  sel_ready_s;
    logic                  m_hready_s;
    logic                  dflt_accept_s;
    logic                  dflt_hready_s;
    logic [1:0]            dflt_hresp_s;

    assign addr_ext_s = 64'(bus.M_HADDR);

    // Slot decode, widened so BASE + N slots never wraps past the address space.
    always_comb begin
        logic [63:0] lo_s;
        lo_s  = '0;
        hit_s = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            lo_s     = slot_base(64'(BASE_ADDR), i, SLOT_SHIFT);
            hit_s[i] = (addr_ext_s >= lo_s) && (addr_ext_s < (lo_s + SLOT_SIZE));
        end
    end

    assign unmapped_s = ~|hit_s;

    // Address-phase fan-out.
    assign bus.S_HSEL   = hit_s;
    assign bus.S_HADDR  = bus.M_HADDR & SLOT_MASK;
    assign bus.S_HTRANS = bus.M_HTRANS;
    assign bus.S_HWRITE = bus.M_HWRITE;
    assign bus.S_HSIZE  = bus.M_HSIZE;
    assign bus.S_HBURST = bus.M_HBURST;
    assign bus.S_HPORT  = bus.M_HPORT;
    assign bus.S_HWDATA = bus.M_HWDATA;

    // Data-phase select follows the pipeline: it only advances when the current
    // data phase completes. Unmapped IDLE/BUSY selects nothing (zero-wait OKAY).
    always_ff @(posedge HCLK or negedge H_nREST) begin
        if (!H_nREST) begin
            dsel_r      <= '0;
            dsel_dflt_r <= 1'b0;
        end else if (m_hready_s) begin
            dsel_r      <= hit_s;
            dsel_dflt_r <= unmapped_s & bus.M_HTRANS[1];
        end else begin
            dsel_r      <= dsel_r;
            dsel_dflt_r <= dsel_dflt_r;
        end
    end

    // AND-OR response mux over the one-hot slave select; with nothing selected
    // this yields 0 / OKAY / ready.
    always_comb begin
        sel_rdata_s = '0;
        sel_resp_s  = HRESP_OKAY;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            sel_rdata_s = sel_rdata_s | ({DATA_WIDTH{dsel_r[i]}} & bus.S_HRDATA[i*DATA_WIDTH +: DATA_WIDTH]);
            sel_resp_s  = sel_resp_s  | ({2{dsel_r[i]}} & bus.S_HRESP[i*2 +: 2]);
        end
        sel_ready_s = (~|dsel_r) | (|(dsel_r & bus.S_HREADYOUT));
    end

    assign m_hready_s   = dsel_dflt_r ? dflt_hready_s : sel_ready_s;
    assign bus.M_HREADY = m_hready_s;
    assign bus.M_HRESP  = dsel_dflt_r ? dflt_hresp_s : sel_resp_s;
    assign bus.M_HRDATA = dsel_dflt_r ? {DATA_WIDTH{1'b0}} : sel_rdata_s;

    assign dflt_accept_s = m_hready_s & unmapped_s & bus.M_HTRANS[1];

    ahb_interconnect_nslv_default_slave #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_W      (16)
    ) u_default_slave (
        .HCLK       (HCLK),
        .H_nREST    (H_nREST),
        .accept     (dflt_accept_s),
        .fault_addr (bus.M_HADDR),
        .flt_clr    (FLT_CLR),
        .hready     (dflt_hready_s),
        .hresp      (dflt_hresp_s),
        .flt_addr   (FLT_ADDR),
        .flt_cnt    (FLT_CNT)
    );

endmodule

// File: tb/tb_ahb_interconnect_nslv.sv
module tb_ahb_interconnect_nslv;
    import ahb_interconnect_nslv_pkg::*;

    localparam int          N     = 4;
    localparam logic [31:0] BASE  = 32'h43C0_0000;
    localparam int          SHIFT = 16;
    localparam longint      SLOT  = 64'd1 << SHIFT;

    logic        HCLK = 1'b0;
    logic        H_nREST;
    logic        FLT_CLR;
    logic [31:0] FLT_ADDR;
    logic [15:0] FLT_CNT;

    logic        sat_accept;
    logic        sat_clr;
    logic [31:0] sat_faddr;
    logic        sat_hready;
    logic [1:0]  sat_hresp;
    logic [31:0] sat_flt_addr;
    logic [2:0]  sat_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state: what is in the data phase, and the fault log.
    int          pend_kind;   // 0 none, 1 slave, 2 default-slave error
    int          pend_idx;
    int          err_left;
    int          m_cnt;
    logic [31:0] m_faddr;
    bit          m_first;

    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic        exp_ready;
    logic [3:0]  exp_hsel;
    logic [31:0] exp_saddr;

    always #5 HCLK = ~HCLK;

    ahb_interconnect_nslv_if #(.SLAVE_NUM(N), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ahb_interconnect_nslv #(
        .SLAVE_NUM(N), .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(BASE), .SLOT_SHIFT(SHIFT)
    ) dut (
        .HCLK(HCLK), .H_nREST(H_nREST), .bus(bus),
        .FLT_ADDR(FLT_ADDR), .FLT_CNT(FLT_CNT), .FLT_CLR(FLT_CLR)
    );

    // Narrow-counter copy of the fault logger so saturation is reachable quickly.
    ahb_interconnect_nslv_default_slave #(.ADDR_WIDTH(32), .CNT_W(3)) u_sat (
        .HCLK(HCLK), .H_nREST(H_nREST), .accept(sat_accept), .fault_addr(sat_faddr),
        .flt_clr(sat_clr), .hready(sat_hready), .hresp(sat_hresp),
        .flt_addr(sat_flt_addr), .flt_cnt(sat_cnt)
    );

    function automatic int slot_of(input logic [31:0] a);
        longint la;
        la = longint'(64'(a));
        if (la >= longint'(64'(BASE)) && la < longint'(64'(BASE)) + N * SLOT)
            return int'((la - longint'(64'(BASE))) / SLOT);
        return -1;
    endfunction

    task automatic model_reset();
        pend_kind = 0; pend_idx = 0; err_left = 0;
        m_cnt = 0; m_faddr = 32'h0; m_first = 1'b0;
    endtask

    task automatic set_addr(input logic [31:0] a, input logic [1:0] tr, input logic wr);
        bus.M_HADDR  = a;
        bus.M_HTRANS = tr;
        bus.M_HWRITE = wr;
        bus.M_HSIZE  = 3'b010;
        bus.M_HBURST = 3'b000;
        bus.M_HPORT  = 4'b0011;
    endtask

    task automatic set_slave(input int i, input logic [31:0] d, input logic [1:0] r, input logic rdy);
        bus.S_HRDATA[i*32 +: 32] = d;
        bus.S_HRESP[i*2 +: 2]    = r;
        bus.S_HREADYOUT[i]       = rdy;
    endtask

    // Expected combinational outputs for the current inputs and model state.
    task automatic settle();
        int s;
        #1;
        case (pend_kind)
            1: begin
                exp_rdata = bus.S_HRDATA[pend_idx*32 +: 32];
                exp_resp  = bus.S_HRESP[pend_idx*2 +: 2];
                exp_ready = bus.S_HREADYOUT[pend_idx];
            end
            2: begin
                exp_rdata = 32'h0;
                exp_resp  = HRESP_ERROR;
                exp_ready = (err_left == 1);
            end
            default: begin
                exp_rdata = 32'h0;
                exp_resp  = HRESP_OKAY;
                exp_ready = 1'b1;
            end
        endcase
        s = slot_of(bus.M_HADDR);
        exp_hsel  = (s >= 0) ? (4'b0001 << s) : 4'b0000;
        exp_saddr = 32'(longint'(64'(bus.M_HADDR)) % SLOT);
    endtask

    // Advance the model by one bus cycle, then move to the next falling edge.
    task automatic clock();
        int s;
        bit fault;
        s = slot_of(bus.M_HADDR);
        fault = exp_ready && (s < 0) && bus.M_HTRANS[1];
        if (FLT_CLR) begin m_cnt = 0; m_faddr = 32'h0; m_first = 1'b0; end
        if (fault) begin
            if (m_cnt < 65535) m_cnt++;
            if (!m_first) begin m_faddr = bus.M_HADDR; m_first = 1'b1; end
        end
        if (exp_ready) begin
            if (s >= 0) begin pend_kind = 1; pend_idx = s; end
            else if (bus.M_HTRANS[1]) begin pend_kind = 2; err_left = 2; end
            else pend_kind = 0;
        end else if (pend_kind == 2) begin
            err_left = 1;
        end
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic test_reset();
        #1;
        n_total++;
        if ({bus.M_HREADY, bus.M_HRESP, bus.M_HRDATA} !== {1'b1, 2'b00, 32'h0}) begin
            n_bad++;
            $display("FAIL reset_bus: got rdy/resp/data=%b/%b/%h want 1/00/0", bus.M_HREADY, bus.M_HRESP, bus.M_HRDATA);
        end
        n_total++;
        if (FLT_CNT !== 16'h0 || FLT_ADDR !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_flt: got cnt=%h addr=%h want 0/0", FLT_CNT, FLT_ADDR);
        end
        @(negedge HCLK);
        H_nREST = 1'b1;
    endtask

    task automatic test_mapped_write();
        set_addr(32'h43C1_0004, HTRANS_NONSEQ, 1'b1);
        settle();
        n_total++;
        if (bus.S_HSEL !== 4'b0010 || bus.S_HADDR !== 32'h4 || bus.S_HWRITE !== 1'b1 || bus.S_HTRANS !== HTRANS_NONSEQ) begin
            n_bad++;
            $display("FAIL t1_addr: got hsel=%b haddr=%h wr=%b tr=%b want 0010/4/1/10", bus.S_HSEL, bus.S_HADDR, bus.S_HWRITE, bus.S_HTRANS);
        end
        clock();
        set_addr(32'h0, HTRANS_IDLE, 1'b0);
        bus.M_HWDATA = 32'hCAFE_0001;
        set_slave(1, 32'h1111_1111, HRESP_OKAY, 1'b1);
        settle();
        n_total++;
        if ({bus.M_HREADY, bus.M_HRESP, bus.M_HRDATA, bus.S_HWDATA} !== {exp_ready, exp_resp, exp_rdata, 32'hCAFE_0001}) begin
            n_bad++;
            $display("FAIL t1_data: got rdy/resp/data/wd=%b/%b/%h/%h want %b/%b/%h/cafe0001", bus.M_HREADY, bus.M_HRESP, bus.M_HRDATA, bus.S_HWDATA, exp_ready, exp_resp, exp_rdata);
        end
        clock();
    endtask

    task automatic test_wait_states();
        set_addr(32'h43C2_0010, HTRANS_NONSEQ, 1'b0);
        settle();
        n_total++;
        if (bus.S_HSEL !== 4'b0100) begin
            n_bad++;
            $display("FAIL t2_hsel: got %b want 0100", bus.S_HSEL);
        end
        clock();
        set_addr(32'h0, HTRANS_IDLE, 1'b0);
        set_slave(2, 32'hDEAD_BEEF, HRESP_OKAY, 1'b0);
        for (int k = 0; k < 3; k++) begin
            settle();
            n_total++;
            if (bus.M_HREADY !== 1'b0 || bus.M_HREADY !== exp_ready) begin
                n_bad++;
                $display("FAIL t2_wait%0d: got rdy=%b want 0", k, bus.M_HREADY);
            end
            clock();
        end
        set_slave(2, 32'hDEAD_BEEF, HRESP_OKAY, 1'b1);
        settle();
        n_total++;
        if ({bus.M_HREADY, bus.M_HRESP, bus.M_HRDATA} !== {1'b1, 2'b00, 32'hDEAD_BEEF}) begin
            n_bad++;
            $display("FAIL t2_done: got rdy/resp/data=%b/%b/%h want 1/00/deadbeef", bus.M_HREADY, bus.M_HRESP, bus.M_HRDATA);
        end
        clock();
    endtask

    task automatic test_unmapped();
        set_addr(32'h43C4_0000, HTRANS_NONSEQ, 1'b0);
        settle();
        n_total++;
        if (bus.S_HSEL !== 4'b0000) begin
            n_bad++;
            $display("FAIL t3_hsel: got %b want 0000", bus.S_HSEL);
        end
        clock();
        set_addr(32'h0, HTRANS_IDLE, 1'b0);
        for (int k = 0; k < 3; k++) begin
            settle();
            n_total++;
            if ({bus.M_HREADY, bus.M_HRESP, bus.M_HRDATA} !== {exp_ready, exp_resp, exp_rdata}) begin
                n_bad++;
                $display("FAIL t3_phase%0d: got rdy/resp/data=%b/%b/%h want %b/%b/%h", k, bus.M_HREADY, bus.M_HRESP, bus.M_HRDATA, exp_ready, exp_resp, exp_rdata);
            end
            n_total++;
            if (FLT_CNT !== 16'd1 || FLT_ADDR !== 32'h43C4_0000) begin
                n_bad++;
                $display("FAIL t3_flt%0d: got cnt=%0d addr=%h want 1/43c40000", k, FLT_CNT, FLT_ADDR);
            end
            clock();
        end
    endtask

    task automatic test_idle_back_to_back();
        set_addr(32'h1000_0000, HTRANS_IDLE, 1'b0);
        FLT_CLR = 1'b1;
        settle();
        clock();
        FLT_CLR = 1'b0;
        settle();
        n_total++;
        if ({bus.M_HREADY, bus.M_HRESP, FLT_CNT} !== {1'b1, 2'b00, 16'd0}) begin
            n_bad++;
            $display("FAIL t4_idle: got rdy/resp/cnt=%b/%b/%0d want 1/00/0", bus.M_HREADY, bus.M_HRESP, FLT_CNT);
        end
        set_addr(32'h1000_0000, HTRANS_NONSEQ, 1'b0);
        settle();
        clock();
        set_addr(32'h0000_0100, HTRANS_SEQ, 1'b0);
        for (int k = 0; k < 4; k++) begin
            settle();
            n_total++;
            if ({bus.M_HREADY, bus.M_HRESP} !== {exp_ready, exp_resp} || bus.M_HREADY !== k[0]) begin
                n_bad++;
                $display("FAIL t4_b2b%0d: got rdy/resp=%b/%b want %b/%b", k, bus.M_HREADY, bus.M_HRESP, exp_ready, exp_resp);
            end
            clock();
            if (k == 1) set_addr(32'h0, HTRANS_IDLE, 1'b0);
        end
        n_total++;
        if (FLT_CNT !== 16'd2 || FLT_ADDR !== 32'h1000_0000) begin
            n_bad++;
            $display("FAIL t4_flt: got cnt=%0d addr=%h want 2/10000000", FLT_CNT, FLT_ADDR);
        end
    endtask

    task automatic test_boundaries();
        logic [31:0] addrs [4];
        logic [3:0]  want  [4];
        addrs[0] = BASE + 32'h0003_FFFF; want[0] = 4'b1000;
        addrs[1] = BASE + 32'h0004_0000; want[1] = 4'b0000;
        addrs[2] = BASE - 32'h1;         want[2] = 4'b0000;
        addrs[3] = 32'hFFFF_FFFF;        want[3] = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            set_addr(addrs[k], HTRANS_IDLE, 1'b0);
            settle();
            n_total++;
            if (bus.S_HSEL !== want[k] || bus.S_HSEL !== exp_hsel || bus.S_HADDR !== exp_saddr) begin
                n_bad++;
                $display("FAIL bound%0d: addr=%h got hsel=%b haddr=%h want %b/%h", k, addrs[k], bus.S_HSEL, bus.S_HADDR, want[k], exp_saddr);
            end
            clock();
        end
    endtask

    task automatic test_reset_midxfer();
        set_addr(32'h43C0_0008, HTRANS_NONSEQ, 1'b0);
        settle();
        clock();
        set_addr(32'h0, HTRANS_IDLE, 1'b0);
        set_slave(0, 32'h5555_AAAA, HRESP_OKAY, 1'b0);
        settle();
        n_total++;
        if (bus.M_HREADY !== 1'b0) begin
            n_bad++;
            $display("FAIL t5_wait: got rdy=%b want 0", bus.M_HREADY);
        end
        #2;
        H_nREST = 1'b0;
        #1;
        model_reset();
        n_total++;
        if ({bus.M_HREADY, bus.M_HRESP, bus.M_HRDATA, FLT_CNT, FLT_ADDR} !== {1'b1, 2'b00, 32'h0, 16'h0, 32'h0}) begin
            n_bad++;
            $display("FAIL t5_rst: got rdy/resp/data/cnt/addr=%b/%b/%h/%h/%h want 1/00/0/0/0", bus.M_HREADY, bus.M_HRESP, bus.M_HRDATA, FLT_CNT, FLT_ADDR);
        end
        @(negedge HCLK);
        H_nREST = 1'b1;
        set_slave(0, 32'h5555_AAAA, HRESP_OKAY, 1'b1);
        set_slave(3, 32'h3333_0003, HRESP_OKAY, 1'b1);
        set_addr(32'h43C3_0000, HTRANS_NONSEQ, 1'b0);
        settle();
        n_total++;
        if (bus.S_HSEL !== 4'b1000) begin
            n_bad++;
            $display("FAIL t5_post_hsel: got %b want 1000", bus.S_HSEL);
        end
        clock();
        set_addr(32'h0, HTRANS_IDLE, 1'b0);
        settle();
        n_total++;
        if ({bus.M_HREADY, bus.M_HRESP, bus.M_HRDATA} !== {1'b1, 2'b00, 32'h3333_0003}) begin
            n_bad++;
            $display("FAIL t5_post_data: got rdy/resp/data=%b/%b/%h want 1/00/33330003", bus.M_HREADY, bus.M_HRESP, bus.M_HRDATA);
        end
        clock();
    endtask

    task automatic test_fault_clr();
        set_addr(32'h0000_1000, HTRANS_NONSEQ, 1'b0);
        settle();
        clock();
        settle();
        clock();
        set_addr(32'h0000_2000, HTRANS_NONSEQ, 1'b0);
        FLT_CLR = 1'b1;
        settle();
        clock();
        FLT_CLR = 1'b0;
        set_addr(32'h0, HTRANS_IDLE, 1'b0);
        n_total++;
        if (FLT_CNT !== 16'd1 || FLT_ADDR !== 32'h0000_2000 || FLT_CNT !== 16'(m_cnt)) begin
            n_bad++;
            $display("FAIL t6_clr_fault: got cnt=%0d addr=%h want 1/00002000", FLT_CNT, FLT_ADDR);
        end
        settle();
        clock();
        settle();
        clock();
    endtask

    task automatic test_saturation();
        int ent;
        ent = 0;
        for (int k = 0; k < 20; k++) begin
            sat_accept = 1'b1;
            sat_faddr  = 32'h100 + 32'(k);
            if (k % 2 == 0) ent++;
            @(posedge HCLK);
            @(negedge HCLK);
            if (k == 0) begin
                n_total++;
                if ({sat_hready, sat_hresp, sat_cnt} !== {1'b0, 2'b01, 3'd1}) begin
                    n_bad++;
                    $display("FAIL sat_err1: got rdy/resp/cnt=%b/%b/%0d want 0/01/1", sat_hready, sat_hresp, sat_cnt);
                end
            end
        end
        n_total++;
        if (sat_cnt !== 3'((ent > 7) ? 7 : ent) || sat_flt_addr !== 32'h100) begin
            n_bad++;
            $display("FAIL sat_cap: got cnt=%0d addr=%h want %0d/100", sat_cnt, sat_flt_addr, (ent > 7) ? 7 : ent);
        end
        sat_accept = 1'b0;
        repeat (2) @(negedge HCLK);
        sat_accept = 1'b1; sat_clr = 1'b1; sat_faddr = 32'h999;
        @(negedge HCLK);
        n_total++;
        if (sat_cnt !== 3'd1 || sat_flt_addr !== 32'h999) begin
            n_bad++;
            $display("FAIL sat_clr_fault: got cnt=%0d addr=%h want 1/999", sat_cnt, sat_flt_addr);
        end
        sat_accept = 1'b0;
        @(negedge HCLK);
        sat_clr = 1'b0;
        n_total++;
        if (sat_cnt !== 3'd0 || sat_flt_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL sat_clr_only: got cnt=%0d addr=%h want 0/0", sat_cnt, sat_flt_addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        hold;
        hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!hold) begin
                case ($urandom_range(0, 6))
                    0, 1, 2: a = BASE + (32'($urandom_range(0, 3)) << SHIFT) + ($urandom & 32'h0000_FFFC);
                    3:       a = BASE + 32'h0003_FFFF + 32'($urandom_range(0, 1));
                    4:       a = $urandom;
                    5:       a = BASE - 32'($urandom_range(1, 4));
                    default: a = BASE + (32'($urandom_range(0, 4)) << SHIFT);
                endcase
                set_addr(a, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                bus.M_HWDATA = $urandom;
            end
            for (int i = 0; i < N; i++)
                set_slave(i, $urandom, ($urandom_range(0, 7) == 0) ? HRESP_ERROR : HRESP_OKAY, $urandom_range(0, 3) != 0);
            FLT_CLR = ($urandom_range(0, 19) == 0);
            settle();
            n_total++;
            if ({bus.M_HREADY, bus.M_HRESP, bus.M_HRDATA} !== {exp_ready, exp_resp, exp_rdata}
                || bus.S_HSEL !== exp_hsel || bus.S_HADDR !== exp_saddr || bus.S_HWDATA !== bus.M_HWDATA) begin
                n_bad++;
                $display("FAIL rnd%0d_bus: addr=%h got rdy/resp/data/hsel/haddr=%b/%b/%h/%b/%h want %b/%b/%h/%b/%h", c, bus.M_HADDR,
                         bus.M_HREADY, bus.M_HRESP, bus.M_HRDATA, bus.S_HSEL, bus.S_HADDR, exp_ready, exp_resp, exp_rdata, exp_hsel, exp_saddr);
            end
            hold = !exp_ready;
            clock();
            n_total++;
            if (FLT_CNT !== 16'(m_cnt) || FLT_ADDR !== m_faddr) begin
                n_bad++;
                $display("FAIL rnd%0d_flt: got cnt=%0d addr=%h want %0d/%h", c, FLT_CNT, FLT_ADDR, m_cnt, m_faddr);
            end
        end
        FLT_CLR = 1'b0;
    endtask

    initial begin
        H_nREST = 1'b0;
        FLT_CLR = 1'b0;
        sat_accept = 1'b0; sat_clr = 1'b0; sat_faddr = 32'h0;
        set_addr(32'h0, HTRANS_IDLE, 1'b0);
        bus.M_HWDATA = 32'h0;
        for (int i = 0; i < N; i++) set_slave(i, 32'h0, HRESP_OKAY, 1'b1);
        model_reset();
        repeat (2) @(negedge HCLK);
        test_reset();
        test_mapped_write();
        test_wait_states();
        test_unmapped();
        test_idle_back_to_back();
        test_boundaries();
        test_reset_midxfer();
        test_fault_clr();
        test_random();
        test_saturation();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
